logic_arbiter: RTL

LOGIC_ARBITER -- requirements
Module: logic_arbiter

---
 rtl/logic_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/logic_arbiter.sv
// ---------------------------------------------------------------------------
// logic_arbiter
//
// Purpose:
//   Two requesters share one bitwise logic unit (AND / OR / NOT / XOR).
//   A three-state FSM (IDLE -> EXEC -> RESP) grants one requester at a time.
//   Ties are resolved round-robin. Each operation occupies the unit for at
//   least three cycles. The response is held under backpressure.
//
// Configuration macro:
//   LOGIC_ARBITER_XOR_EN
//     defined   : op=3 returns a^b with rsp_err=0
//     undefined : op=3 returns 0 with rsp_err=1
//
// Ports:
//   clk                 in   single clock, rising edge
//   rst                 in   synchronous active-high reset
//   req0_valid/ready    in/out  requester 0 handshake (ready is combinational)
//   req0_op             in   2-bit opcode: 0=AND 1=OR 2=NOT(a) 3=XOR
//   req0_a, req0_b      in   WIDTH-bit operands
//   req1_*              same as req0_* for requester 1
//   rsp_valid           out  result available (registered, RESP state only)
//   rsp_ready           in   consumer accepts the result
//   rsp_data            out  WIDTH-bit result
//   rsp_id              out  owner of the result (0 or 1)
//   rsp_err             out  unsupported opcode was issued
// ---------------------------------------------------------------------------
module logic_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_prio;   // requester that wins the next tie
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;

  logic             w_grant;
  logic             w_grant_id;
  logic [WIDTH-1:0] w_result;
  logic             w_err;

  // A grant happens only in IDLE. Reset gating keeps both ready lines low
  // while rst is asserted, even if the FSM is already sitting in IDLE.
  assign w_grant    = (r_state == IDLE) && !rst && (req0_valid || req1_valid);
  // When only one requester is valid it wins outright. On a tie the
  // round-robin pointer decides.
  assign w_grant_id = (req0_valid && req1_valid) ? r_prio : req1_valid;

  assign req0_ready = w_grant && !w_grant_id;
  assign req1_ready = w_grant &&  w_grant_id;

  // Shared logic unit, fed from the captured operands
  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_op)
      2'd0: w_result = r_a & r_b;
      2'd1: w_result = r_a | r_b;
      2'd2: w_result = ~r_a;
      2'd3: begin
`ifdef LOGIC_ARBITER_XOR_EN
        w_result = r_a ^ r_b;
        w_err    = 1'b0;
`else
        w_result = '0;
        w_err    = 1'b1;
`endif
      end
      default: begin
        w_result = '0;
        w_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_prio    <= 1'b0;
      r_op      <= 2'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_op    <= w_grant_id ? req1_op : req0_op;
            r_a     <= w_grant_id ? req1_a  : req0_a;
            r_b     <= w_grant_id ? req1_b  : req0_b;
            r_id    <= w_grant_id;
            // The pointer moves only on a real grant. Dropped requests leave it alone.
            r_prio  <= ~w_grant_id;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= w_result;
          rsp_id    <= r_id;
          rsp_err   <= w_err;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          // The response registers are written only in EXEC, so they stay
          // stable for as long as the consumer stalls.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
